// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode seven-segment scanner. Values are posted into a
// pending register and only reach the display at a frame boundary, so a frame never tears.
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 2,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [6:0]  segments,
    output logic        dp,
    output logic [3:0]  anode_active,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] TERM  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYC);

    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    idx, idx_next;
    logic [15:0]   disp, pend;
    logic [3:0]    dp_disp, pend_dp;
    logic          pend_valid;
    logic          terminal, boundary, lead_zero;
    logic [3:0]    nibble;
    logic [6:0]    seg_next;

    // Segment vector bit 6 is segment a, bit 0 is segment g; 0 = lit.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b0000001;
            4'h1:    hex7 = 7'b1001111;
            4'h2:    hex7 = 7'b0010010;
            4'h3:    hex7 = 7'b0000110;
            4'h4:    hex7 = 7'b1001100;
            4'h5:    hex7 = 7'b0100100;
            4'h6:    hex7 = 7'b0100000;
            4'h7:    hex7 = 7'b0001111;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0001100;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b1100000;
            4'hC:    hex7 = 7'b0110001;
            4'hD:    hex7 = 7'b1000010;
            4'hE:    hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    assign terminal = (cnt == TERM);
    assign boundary = en && terminal && (idx == 2'd3);
    assign nibble   = disp[{idx, 2'b00} +: 4];

    always_comb begin
        cnt_next = cnt + 1'b1;
        idx_next = idx;
        if (!en) begin
            cnt_next = '0;
            idx_next = '0;
        end else if (terminal) begin
            cnt_next = '0;
            idx_next = idx + 2'd1;
        end
    end

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        lead_zero = 1'b0;
        case (idx)
            2'd1:    lead_zero = (disp[15:4] == 12'h000);
            2'd2:    lead_zero = (disp[15:8] == 8'h00);
            2'd3:    lead_zero = (disp[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
        seg_next = (LZ_BLANK && lead_zero) ? 7'h7F : hex7(nibble);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_next;
            idx <= idx_next;
        end
    end

    // A load that coincides with the boundary bypasses pending and lands on the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp       <= '0;
            dp_disp    <= '0;
            pend       <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                disp    <= value;
                dp_disp <= dp_in;
            end else if (pend_valid) begin
                disp    <= pend;
                dp_disp <= pend_dp;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pend       <= value;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_active <= 4'hF;
            segments     <= 7'h7F;
            dp           <= 1'b1;
            frame_done   <= 1'b0;
        end else begin
            if (!en || cnt < BLANK) begin
                anode_active <= 4'hF;
                segments     <= 7'h7F;
                dp           <= 1'b1;
            end else begin
                anode_active <= ~(4'b0001 << idx);
                segments     <= seg_next;
                dp           <= ~dp_disp[idx];
            end
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a cycle model queues expected outputs per edge,
// and each scenario task also checks hand-derived constants for its frame.
module tb_seven_seg_scanner;

    localparam int R = 4;
    localparam int B = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anode_active;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int passes = 0;

    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic [3:0]  m_dpd = 4'h0;
    logic [3:0]  m_pdp = 4'h0;
    logic        m_pv = 1'b0;

    logic [6:0] hexmap [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seven_seg_scanner #(.REFRESH_DIV(R), .BLANK_CYC(B), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_in(dp_in), .load(load),
        .segments(segments), .dp(dp), .anode_active(anode_active), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Predict the outputs of the coming edge, queue them, advance the model, then clock.
    task automatic tick();
        exp_t e;
        logic bnd;
        e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
        bnd = en && (m_cnt == R - 1) && (m_idx == 3);
        if (en) begin
            e.fd = bnd;
            if (m_cnt >= B) begin
                e.an  = ~(4'b0001 << m_idx);
                e.seg = (m_idx != 0 && (m_disp >> (4 * m_idx)) == 16'h0) ? 7'h7F
                        : hexmap[m_disp[4 * m_idx +: 4]];
                e.dp  = ~m_dpd[m_idx];
            end
        end
        sbq.push_back(e);
        if (bnd) begin
            if (load) begin
                m_disp = value;
                m_dpd  = dp_in;
            end else if (m_pv) begin
                m_disp = m_pend;
                m_dpd  = m_pdp;
            end
            m_pv = 1'b0;
        end else if (load) begin
            m_pend = value;
            m_pdp  = dp_in;
            m_pv   = 1'b1;
        end
        if (!en) begin
            m_cnt = 0;
            m_idx = 0;
        end else if (m_cnt == R - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sync_frame();
        int n = 0;
        while (!(m_cnt == 0 && m_idx == 0 && !m_pv) && n < 64) begin
            tick();
            void'(sbq.pop_front());
            n++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (anode_active !== 4'hF) $display("[TB] FAIL reset_anode: got %b want 1111", anode_active); else passes++;
        checks++; if (segments !== 7'h7F) $display("[TB] FAIL reset_seg: got %b want 1111111", segments); else passes++;
        checks++; if (dp !== 1'b1) $display("[TB] FAIL reset_dp: got %b want 1", dp); else passes++;
        checks++; if (frame_done !== 1'b0) $display("[TB] FAIL reset_fd: got %b want 0", frame_done); else passes++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en = 1'b1;
    endtask

    task automatic test_scan();
        exp_t e;
        logic [3:0] want_an;
        logic [6:0] want;
        load = 1'b1; value = 16'h12AF; dp_in = 4'h0;
        tick();
        load = 1'b0;
        void'(sbq.pop_front());
        sync_frame();
        for (int j = 0; j < 16; j++) begin
            tick();
            e = sbq.pop_front();
            checks++;
            if (anode_active !== e.an || frame_done !== e.fd || (e.an != 4'hF && (segments !== e.seg || dp !== e.dp)))
                $display("[TB] FAIL scan_model: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                         anode_active, segments, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            else passes++;
            want_an = (j % 4 == 0) ? 4'hF : ~(4'b0001 << (j / 4));
            checks++;
            if (anode_active !== want_an || frame_done !== (j == 15))
                $display("[TB] FAIL scan_seq: j=%0d got an=%b fd=%b want an=%b fd=%b", j, anode_active, frame_done, want_an, j == 15);
            else passes++;
            if (j % 4 != 0) begin
                case (j / 4)
                    0:       want = 7'b0111000;
                    1:       want = 7'b0001000;
                    2:       want = 7'b0010010;
                    default: want = 7'b1001111;
                endcase
                checks++;
                if (segments !== want) $display("[TB] FAIL scan_seg: j=%0d got %b want %b", j, segments, want);
                else passes++;
            end
        end
    endtask

    task automatic test_tear_free();
        exp_t e;
        int fd_count = 0;
        load = 1'b1; value = 16'hFFFF;
        tick();
        load = 1'b0;
        void'(sbq.pop_front());
        sync_frame();
        for (int j = 0; j < 32; j++) begin
            if (j == 5) begin
                load = 1'b1;
                value = 16'h0001;
            end
            tick();
            load = 1'b0;
            e = sbq.pop_front();
            checks++;
            if (anode_active !== e.an || frame_done !== e.fd || (e.an != 4'hF && (segments !== e.seg || dp !== e.dp)))
                $display("[TB] FAIL tear_model: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                         anode_active, segments, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            else passes++;
            if (j < 16 && frame_done === 1'b1) fd_count++;
            if (j < 16 && j / 4 >= 2 && j % 4 != 0) begin
                checks++;
                if (segments !== 7'b0111000) $display("[TB] FAIL tear_old: j=%0d got %b want 0111000", j, segments);
                else passes++;
            end
            if (j >= 16 && j % 4 != 0) begin
                checks++;
                if (segments !== ((j / 4 == 4) ? 7'b1001111 : 7'h7F))
                    $display("[TB] FAIL tear_new: j=%0d got %b", j, segments);
                else passes++;
            end
        end
        checks++;
        if (fd_count != 1) $display("[TB] FAIL tear_fd_count: got %0d want 1", fd_count); else passes++;
    endtask

    task automatic test_lz();
        exp_t e;
        logic [6:0] want;
        for (int pass = 0; pass < 2; pass++) begin
            load = 1'b1; value = (pass == 0) ? 16'h0050 : 16'h0000; dp_in = 4'h0;
            tick();
            load = 1'b0;
            void'(sbq.pop_front());
            sync_frame();
            for (int j = 0; j < 16; j++) begin
                tick();
                e = sbq.pop_front();
                checks++;
                if (anode_active !== e.an || frame_done !== e.fd || (e.an != 4'hF && (segments !== e.seg || dp !== e.dp)))
                    $display("[TB] FAIL lz_model: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                             anode_active, segments, dp, frame_done, e.an, e.seg, e.dp, e.fd);
                else passes++;
                if (j % 4 != 0) begin
                    case (j / 4)
                        0:       want = 7'b0000001;
                        1:       want = (pass == 0) ? 7'b0100100 : 7'h7F;
                        default: want = 7'h7F;
                    endcase
                    checks++;
                    if (segments !== want || anode_active !== ~(4'b0001 << (j / 4)) || dp !== 1'b1)
                        $display("[TB] FAIL lz_digit: pass=%0d j=%0d got an=%b seg=%b dp=%b want seg=%b", pass, j, anode_active, segments, dp, want);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_enable();
        exp_t e;
        for (int j = 0; j < 6; j++) begin
            tick();
            void'(sbq.pop_front());
        end
        en = 1'b0;
        for (int j = 0; j < 10; j++) begin
            load = (j == 0); value = 16'h1234;
            tick();
            load = 1'b0;
            e = sbq.pop_front();
            checks++;
            if (anode_active !== 4'hF || frame_done !== 1'b0 || anode_active !== e.an)
                $display("[TB] FAIL en_off: j=%0d got an=%b fd=%b want an=1111 fd=0", j, anode_active, frame_done);
            else passes++;
        end
        en = 1'b1;
        for (int j = 0; j < 2; j++) begin
            tick();
            e = sbq.pop_front();
            checks++;
            if (anode_active !== ((j == 0) ? 4'hF : 4'b1110) || anode_active !== e.an || segments !== e.seg)
                $display("[TB] FAIL en_restart: j=%0d got an=%b seg=%b want an=%b", j, anode_active, segments, (j == 0) ? 4'hF : 4'b1110);
            else passes++;
        end
        sync_frame();
        for (int j = 0; j < 16; j++) begin
            tick();
            e = sbq.pop_front();
            checks++;
            if (anode_active !== e.an || frame_done !== e.fd || (e.an != 4'hF && (segments !== e.seg || dp !== e.dp)))
                $display("[TB] FAIL en_model: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                         anode_active, segments, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            else passes++;
            if (j % 4 != 0 && (j / 4 == 0 || j / 4 == 3)) begin
                checks++;
                if (segments !== ((j / 4 == 0) ? 7'b1001100 : 7'b1001111))
                    $display("[TB] FAIL en_pending: j=%0d got %b", j, segments);
                else passes++;
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n = 0;
        while (!(m_cnt == R - 1 && m_idx == 3) && n < 64) begin
            tick();
            void'(sbq.pop_front());
            n++;
        end
        load = 1'b1; value = 16'h8888; dp_in = 4'b0100;
        tick();
        load = 1'b0; dp_in = 4'h0;
        e = sbq.pop_front();
        checks++;
        if (frame_done !== 1'b1 || e.fd !== 1'b1) $display("[TB] FAIL bload_fd: got %b want 1", frame_done); else passes++;
        for (int j = 0; j < 16; j++) begin
            tick();
            e = sbq.pop_front();
            checks++;
            if (anode_active !== e.an || frame_done !== e.fd || (e.an != 4'hF && (segments !== e.seg || dp !== e.dp)))
                $display("[TB] FAIL bload_model: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                         anode_active, segments, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            else passes++;
            if (j % 4 != 0) begin
                checks++;
                if (segments !== 7'b0000000 || dp !== ((j / 4 == 2) ? 1'b0 : 1'b1))
                    $display("[TB] FAIL bload_digit: j=%0d got seg=%b dp=%b want seg=0000000 dp=%b", j, segments, dp, (j / 4 == 2) ? 1'b0 : 1'b1);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int j = 0; j < 6; j++) begin
            load = (j == 4); value = 16'hABCD;
            tick();
            load = 1'b0;
            void'(sbq.pop_front());
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (anode_active !== 4'hF || segments !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0)
            $display("[TB] FAIL reset_mid: got an=%b seg=%b dp=%b fd=%b want 1111 1111111 1 0", anode_active, segments, dp, frame_done);
        else passes++;
        m_cnt = 0; m_idx = 0; m_disp = 16'h0; m_pend = 16'h0; m_dpd = 4'h0; m_pdp = 4'h0; m_pv = 1'b0;
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j < 32; j++) begin
            tick();
            e = sbq.pop_front();
            checks++;
            if (anode_active !== e.an || frame_done !== e.fd || (e.an != 4'hF && (segments !== e.seg || dp !== e.dp)))
                $display("[TB] FAIL rmid_model: got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                         anode_active, segments, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            else passes++;
            if (j >= 16 && j % 4 != 0) begin
                checks++;
                if (segments !== ((j / 4 == 4) ? 7'b0000001 : 7'h7F))
                    $display("[TB] FAIL rmid_discard: j=%0d got %b", j, segments);
                else passes++;
            end
        end
    endtask

    initial begin
        $display("[TB] seven_seg_scanner bench start");
        test_reset();
        test_scan();
        test_tear_free();
        test_lz();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
